dmem_apb_arbiter: RTL

//  Two-requester APB master that shares the data-memory APB slave between the core LSU
//  (port 0) and a debug/DMA agent (port 1). It uses round-robin arbitration and runs the
//  APB SETUP/ACCESS sequence. For writes it aligns sub-word data into lanes and generates

---
 rtl/dmem_apb_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_apb_arbiter.sv
// dmem_apb_arbiter: shares the data-memory APB slave between the core LSU
// (port 0) and a debug/DMA agent (port 1). Round-robin arbitration, one APB
// transfer at a time. Stores are lane-aligned with byte strobes. Loads fetch
// the full word and extract/extend the requested sub-word locally.
//
// Request handshake: a requester raises req_valid_i[n] with a stable payload
// and holds both until the cycle where req_ready_o[n] is high. That cycle's
// rising edge is the accept edge. req_ready_o is at most one-hot and is only
// ever high in IDLE. Exactly one rsp_valid_o[id] strobe follows each accepted
// request, unless reset intervenes.
module dmem_apb_arbiter #(
    parameter int DMEM_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*DMEM_W-1:0] req_addr_i,
    input  logic [1:0]          req_write_i,
    input  logic [63:0]         req_wdata_i,
    input  logic [5:0]          req_size_i,
    output logic [1:0]          rsp_valid_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic [DMEM_W-1:0]   paddr_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [31:0]         pwdata_o,
    output logic [3:0]          pstrb_o,
    output logic [2:0]          sel_mod_o,
    input  logic [31:0]         prdata_i,
    input  logic                pready_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             cur_id;
    logic [1:0]       cur_lane;
    logic             cur_write;
    logic [2:0]       cur_size;
    logic [CNT_W-1:0] wait_cnt;

    logic              any_valid;
    logic              grant_id;
    logic [DMEM_W-1:0] sel_addr;
    logic              sel_write;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_size;
    logic              align_err;
    logic [3:0]        sel_strb;
    logic [31:0]       byte_shift;
    logic [31:0]       half_shift;
    logic [31:0]       load_data;

    // The memory always returns whole words.
    assign sel_mod_o = 3'b010;

    // Round-robin pick and the combinational accept, only offered in IDLE.
    always_comb begin
        any_valid = |req_valid_i;
        if (req_valid_i == 2'b11) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req_valid_i[1];
        end
        req_ready_o = 2'b00;
        if (state == S_IDLE && any_valid) begin
            req_ready_o = grant_id ? 2'b10 : 2'b01;
        end
    end

    // Payload of the requester being granted, alignment check and store strobes.
    always_comb begin
        sel_addr  = grant_id ? req_addr_i[2*DMEM_W-1:DMEM_W] : req_addr_i[DMEM_W-1:0];
        sel_write = grant_id ? req_write_i[1] : req_write_i[0];
        sel_wdata = grant_id ? req_wdata_i[63:32] : req_wdata_i[31:0];
        sel_size  = grant_id ? req_size_i[5:3] : req_size_i[2:0];
        align_err = (sel_size[1:0] == 2'b11)
                  | ((sel_size[1:0] == 2'b01) & sel_addr[0])
                  | ((sel_size[1:0] == 2'b10) & (|sel_addr[1:0]));
        case (sel_size[1:0])
            2'b00:   sel_strb = 4'b0001 << sel_addr[1:0];
            2'b01:   sel_strb = 4'b0011 << sel_addr[1:0];
            default: sel_strb = 4'b1111;
        endcase
    end

    // Sub-word extraction and sign/zero extension of the fetched word.
    always_comb begin
        byte_shift = prdata_i >> {cur_lane, 3'b000};
        half_shift = prdata_i >> {cur_lane[1], 4'b0000};
        case (cur_size[1:0])
            2'b00: load_data = cur_size[2] ? {24'd0, byte_shift[7:0]}
                                           : {{24{byte_shift[7]}}, byte_shift[7:0]};
            2'b01: load_data = cur_size[2] ? {16'd0, half_shift[15:0]}
                                           : {{16{half_shift[15]}}, half_shift[15:0]};
            default: load_data = prdata_i;
        endcase
    end

    // Transfer sequencer: accept, SETUP, ACCESS with timeout, one-cycle response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            cur_lane    <= 2'b00;
            cur_write   <= 1'b0;
            cur_size    <= 3'b000;
            wait_cnt    <= '0;
            paddr_o     <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= 32'd0;
            pstrb_o     <= 4'b0000;
            rsp_valid_o <= 2'b00;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        cur_lane   <= sel_addr[1:0];
                        cur_write  <= sel_write;
                        cur_size   <= sel_size;
                        if (align_err) begin
                            // Bad request: answer directly, no bus traffic.
                            state       <= S_RESP;
                            rsp_valid_o <= grant_id ? 2'b10 : 2'b01;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= 32'd0;
                        end else begin
                            state    <= S_SETUP;
                            psel_o   <= 1'b1;
                            paddr_o  <= {sel_addr[DMEM_W-1:2], 2'b00};
                            pwrite_o <= sel_write;
                            pwdata_o <= sel_wdata << {sel_addr[1:0], 3'b000};
                            pstrb_o  <= sel_write ? sel_strb : 4'b0000;
                        end
                    end
                end
                S_SETUP: begin
                    state     <= S_ACCESS;
                    penable_o <= 1'b1;
                    wait_cnt  <= '0;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        state       <= S_RESP;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= cur_id ? 2'b10 : 2'b01;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= cur_write ? 32'd0 : load_data;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Slave never answered: abandon the transfer with an error.
                        state       <= S_RESP;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= cur_id ? 2'b10 : 2'b01;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    rsp_valid_o <= 2'b00;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= 32'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
